// File: rtl/exception_ctrl_if.sv
// MEM-stage exception port bundle: pipeline/CP0 inputs plus the registered
// exception report and flush/redirect outputs.
interface exception_ctrl_if;
  logic        mem_valid_i;
  logic        stall_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  exc_flags_i;
  logic        eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic [31:0] excepttype_o;
  logic [31:0] exc_pc_o;
  logic        exc_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output mem_valid_i, stall_i, pc_i, in_delayslot_i, mem_addr_i, exc_flags_i,
           eret_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_we_i, cp0_waddr_i,
           cp0_wdata_i,
    input  excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o, new_pc_o
  );

  modport slave (
    input  mem_valid_i, stall_i, pc_i, in_delayslot_i, mem_addr_i, exc_flags_i,
           eret_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_we_i, cp0_waddr_i,
           cp0_wdata_i,
    output excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: fixed-priority select, registered CP0 report,
// one-cycle pipeline flush with redirect PC.
module exception_ctrl (
  input  logic             clk,
  input  logic             rst,
  exception_ctrl_if.slave  bus
);
  localparam int unsigned W = 32;
  localparam logic [W-1:0] EXC_VECTOR = 32'hBFC00380;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [W-1:0] T_INT  = 32'h1;
  localparam logic [W-1:0] T_ADEL = 32'h4;
  localparam logic [W-1:0] T_ADES = 32'h5;
  localparam logic [W-1:0] T_SYS  = 32'h8;
  localparam logic [W-1:0] T_BRK  = 32'h9;
  localparam logic [W-1:0] T_RI   = 32'ha;
  localparam logic [W-1:0] T_OV   = 32'hc;
  localparam logic [W-1:0] T_TRAP = 32'hd;
  localparam logic [W-1:0] T_ERET = 32'he;

  logic [0:0]   r_state, w_state_nxt;
  logic [W-1:0] r_type, r_exc_pc, r_bad_addr, r_new_pc;
  logic         r_delayslot, r_flush;

  logic [W-1:0] w_status, w_epc, w_type, w_bad_addr, w_new_pc;
  logic [7:0]   w_cause_ip;
  logic         w_int, w_commit;
  logic [W-1:0] w_type_nxt, w_exc_pc_nxt, w_bad_nxt, w_new_pc_nxt;
  logic         w_ds_nxt, w_flush_nxt;
  logic         w_unused_ok;

  // A same-cycle MTC0 is visible to this cycle's decision; cause forwards only IP[1:0]
  assign w_status = (bus.cp0_we_i && bus.cp0_waddr_i == CP0_STATUS) ? bus.cp0_wdata_i
                                                                    : bus.cp0_status_i;
  assign w_epc    = (bus.cp0_we_i && bus.cp0_waddr_i == CP0_EPC) ? bus.cp0_wdata_i
                                                                 : bus.cp0_epc_i;
  assign w_cause_ip = {bus.cp0_cause_i[15:10],
                       (bus.cp0_we_i && bus.cp0_waddr_i == CP0_CAUSE) ? bus.cp0_wdata_i[9:8]
                                                                      : bus.cp0_cause_i[9:8]};

  assign w_int = (|(w_status[15:8] & w_cause_ip)) && w_status[0] && !w_status[1];

  assign w_unused_ok = &{1'b0, w_status[31:16], w_status[7:2], bus.cp0_cause_i[31:16],
                         bus.cp0_cause_i[7:0], bus.cp0_wdata_i[31:10], bus.cp0_wdata_i[7:0]};

  // Fixed-priority exception select
  always_comb begin
    w_type     = '0;
    w_bad_addr = '0;
    if (w_int)                     w_type = T_INT;
    else if (bus.exc_flags_i[0]) begin
      w_type     = T_ADEL;
      w_bad_addr = bus.pc_i;
    end
    else if (bus.exc_flags_i[1])   w_type = T_RI;
    else if (bus.exc_flags_i[2])   w_type = T_SYS;
    else if (bus.exc_flags_i[3])   w_type = T_BRK;
    else if (bus.exc_flags_i[4])   w_type = T_OV;
    else if (bus.exc_flags_i[5])   w_type = T_TRAP;
    else if (bus.exc_flags_i[6]) begin
      w_type     = T_ADEL;
      w_bad_addr = bus.mem_addr_i;
    end
    else if (bus.exc_flags_i[7]) begin
      w_type     = T_ADES;
      w_bad_addr = bus.mem_addr_i;
    end
    else if (bus.eret_i)           w_type = T_ERET;
  end

  assign w_new_pc = (w_type == T_ERET) ? w_epc : EXC_VECTOR;

  // Next state and next registered report; FLUSH squashes the MEM instruction
  always_comb begin
    w_state_nxt  = r_state;
    w_commit     = 1'b0;
    w_type_nxt   = '0;
    w_exc_pc_nxt = '0;
    w_ds_nxt     = 1'b0;
    w_bad_nxt    = '0;
    w_flush_nxt  = 1'b0;
    w_new_pc_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        w_commit = bus.mem_valid_i && !bus.stall_i && (w_type != '0);
        if (w_commit) begin
          w_state_nxt  = ST_FLUSH;
          w_type_nxt   = w_type;
          w_exc_pc_nxt = bus.pc_i;
          w_ds_nxt     = bus.in_delayslot_i;
          w_bad_nxt    = w_bad_addr;
          w_flush_nxt  = 1'b1;
          w_new_pc_nxt = w_new_pc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_type      <= '0;
      r_exc_pc    <= '0;
      r_delayslot <= 1'b0;
      r_bad_addr  <= '0;
      r_flush     <= 1'b0;
      r_new_pc    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_type      <= w_type_nxt;
      r_exc_pc    <= w_exc_pc_nxt;
      r_delayslot <= w_ds_nxt;
      r_bad_addr  <= w_bad_nxt;
      r_flush     <= w_flush_nxt;
      r_new_pc    <= w_new_pc_nxt;
    end
  end

  assign bus.excepttype_o    = r_type;
  assign bus.exc_pc_o        = r_exc_pc;
  assign bus.exc_delayslot_o = r_delayslot;
  assign bus.bad_addr_o      = r_bad_addr;
  assign bus.flush_o         = r_flush;
  assign bus.new_pc_o        = r_new_pc;
endmodule

// File: tb/tb_exception_ctrl.sv
// Directed, table-driven bench for exception_ctrl plus stall, back-to-back
// and reset-in-flush sequences.
module tb_exception_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  exception_ctrl_if bus();
  exception_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] addr;
    logic [7:0]  flags;
    logic        eret;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_type;
    logic [31:0] e_pc;
    logic        e_ds;
    logic [31:0] e_bad;
    logic        e_flush;
    logic [31:0] e_newpc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] t, input logic [31:0] pc,
                         input logic ds, input logic [31:0] ba, input logic fl,
                         input logic [31:0] np);
    chk({tag, ".type"},  bus.excepttype_o, t);
    chk({tag, ".pc"},    bus.exc_pc_o, pc);
    chk({tag, ".ds"},    32'(bus.exc_delayslot_o), 32'(ds));
    chk({tag, ".bad"},   bus.bad_addr_o, ba);
    chk({tag, ".flush"}, 32'(bus.flush_o), 32'(fl));
    chk({tag, ".newpc"}, bus.new_pc_o, np);
  endtask

  task automatic clear_inputs();
    bus.mem_valid_i = 1'b0; bus.stall_i = 1'b0; bus.pc_i = '0; bus.in_delayslot_i = 1'b0;
    bus.mem_addr_i = '0; bus.exc_flags_i = '0; bus.eret_i = 1'b0;
    bus.cp0_status_i = '0; bus.cp0_cause_i = '0; bus.cp0_epc_i = '0;
    bus.cp0_we_i = 1'b0; bus.cp0_waddr_i = '0; bus.cp0_wdata_i = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.mem_valid_i = v.valid; bus.stall_i = 1'b0; bus.pc_i = v.pc;
    bus.in_delayslot_i = v.ds; bus.mem_addr_i = v.addr; bus.exc_flags_i = v.flags;
    bus.eret_i = v.eret; bus.cp0_status_i = v.status; bus.cp0_cause_i = v.cause;
    bus.cp0_epc_i = v.epc; bus.cp0_we_i = v.we; bus.cp0_waddr_i = v.waddr;
    bus.cp0_wdata_i = v.wdata;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // valid pc ds addr flags eret status cause epc we waddr wdata | type pc ds bad flush newpc
    vecs[0]  = '{1'b1, 32'h80001000, 1'b0, 32'h0, 8'h10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'hc, 32'h80001000, 1'b0, 32'h0, 1'b1, VEC};
    vecs[1]  = '{1'b1, 32'h80000020, 1'b1, 32'h3, 8'h80, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h5, 32'h80000020, 1'b1, 32'h3, 1'b1, VEC};
    vecs[2]  = '{1'b1, 32'h80000040, 1'b0, 32'h0, 8'h04, 1'b0, 32'h401, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h1, 32'h80000040, 1'b0, 32'h0, 1'b1, VEC};
    vecs[3]  = '{1'b1, 32'h80000040, 1'b0, 32'h0, 8'h04, 1'b0, 32'h403, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h8, 32'h80000040, 1'b0, 32'h0, 1'b1, VEC};
    vecs[4]  = '{1'b1, 32'h80000060, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0, 32'h0, 32'h80000100, 1'b1, 5'd14, 32'h80000200,
                 32'he, 32'h80000060, 1'b0, 32'h0, 1'b1, 32'h80000200};
    vecs[5]  = '{1'b1, 32'h80000abc, 1'b0, 32'h1234, 8'h43, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h4, 32'h80000abc, 1'b0, 32'h80000abc, 1'b1, VEC};
    vecs[6]  = '{1'b1, 32'h80000070, 1'b0, 32'h0, 8'h38, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h9, 32'h80000070, 1'b0, 32'h0, 1'b1, VEC};
    vecs[7]  = '{1'b1, 32'h80000080, 1'b0, 32'h11, 8'h40, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h4, 32'h80000080, 1'b0, 32'h11, 1'b1, VEC};
    vecs[8]  = '{1'b0, 32'h80000088, 1'b0, 32'h0, 8'h02, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h80000090, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 32'h400, 32'h0, 1'b1, 5'd12, 32'h401,
                 32'h1, 32'h80000090, 1'b0, 32'h0, 1'b1, VEC};
    vecs[10] = '{1'b0, 32'h80000094, 1'b0, 32'h0, 8'h00, 1'b0, 32'h401, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h800000a0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h301, 32'h0, 32'h0, 1'b1, 5'd13, 32'h100,
                 32'h1, 32'h800000a0, 1'b0, 32'h0, 1'b1, VEC};
    vecs[12] = '{1'b1, 32'h800000a4, 1'b0, 32'h0, 8'h00, 1'b0, 32'h401, 32'h0, 32'h0, 1'b1, 5'd13, 32'h400,
                 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h800000b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0, 32'h0, 32'h80000100, 1'b0, 5'd0, 32'h0,
                 32'he, 32'h800000b0, 1'b0, 32'h0, 1'b1, 32'h80000100};
    vecs[14] = '{1'b1, 32'h800000c0, 1'b0, 32'h0, 8'h20, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'hd, 32'h800000c0, 1'b0, 32'h0, 1'b1, VEC};
    vecs[15] = '{1'b1, 32'h800000d0, 1'b1, 32'h0, 8'h04, 1'b1, 32'h0, 32'h0, 32'h80000100, 1'b0, 5'd0, 32'h0,
                 32'h8, 32'h800000d0, 1'b1, 32'h0, 1'b1, VEC};

    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;

    // Each vector: report at T+1, everything back to zero at T+2
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_type, vecs[i].e_pc, vecs[i].e_ds,
              vecs[i].e_bad, vecs[i].e_flush, vecs[i].e_newpc);
      clear_inputs();
      step();
      chk_all($sformatf("vec%0d_clr", i), 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    end

    // RI held under a 3-cycle stall, commits on the first unstalled cycle
    bus.mem_valid_i = 1'b1; bus.pc_i = 32'h80000100; bus.exc_flags_i = 8'h02; bus.stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall%0d.type", c), bus.excepttype_o, 32'h0);
      chk($sformatf("stall%0d.flush", c), 32'(bus.flush_o), 32'h0);
    end
    bus.stall_i = 1'b0;
    step();
    chk_all("unstall", 32'ha, 32'h80000100, 1'b0, 32'h0, 1'b1, VEC);
    clear_inputs();
    step();
    chk_all("unstall_clr", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Back-to-back: T reported, T+1 squashed, T+2 is the earliest next commit
    bus.mem_valid_i = 1'b1; bus.pc_i = 32'h80000200; bus.exc_flags_i = 8'h10;
    step();
    chk_all("b2b_t1", 32'hc, 32'h80000200, 1'b0, 32'h0, 1'b1, VEC);
    bus.pc_i = 32'h80000204; bus.exc_flags_i = 8'h04;
    step();
    chk_all("b2b_t2", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.pc_i = 32'h80000208; bus.exc_flags_i = 8'h08;
    step();
    chk_all("b2b_t3", 32'h9, 32'h80000208, 1'b0, 32'h0, 1'b1, VEC);
    clear_inputs();
    step();

    // Reset while in FLUSH
    bus.mem_valid_i = 1'b1; bus.pc_i = 32'h80000300; bus.exc_flags_i = 8'h10;
    step();
    chk("rstflush_pre.flush", 32'(bus.flush_o), 32'h1);
    clear_inputs();
    rst = 1'b0;
    step();
    chk_all("rstflush", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    bus.mem_valid_i = 1'b1; bus.pc_i = 32'h80000310; bus.exc_flags_i = 8'h08;
    step();
    chk_all("after_rst", 32'h9, 32'h80000310, 1'b0, 32'h0, 1'b1, VEC);
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

MEM-stage exception arbiter and the producer side of the CP0 exception port. It collects per-instruction exception flags and pending interrupts, and selects one exception by fixed priority. It drives the registered exception report that CP0 latches: type, instruction address, delay-slot flag and bad address. It also issues the pipeline flush and redirect PC, and suppresses the wrong-path instruction that follows a commit.

## Interface
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- mem_valid_i  in  1  an instruction occupies MEM this cycle
- stall_i  in  1  MEM stage frozen (memory wait); no commit while high
- pc_i  in  32  address of the MEM instruction
- in_delayslot_i  in  1  MEM instruction sits in a branch delay slot
- mem_addr_i  in  32  data address of a load/store
- exc_flags_i  in  8  [0] fetch AdEL, [1] RI, [2] syscall, [3] break, [4] overflow, [5] trap, [6] data AdEL, [7] data AdES
- eret_i  in  1  MEM instruction is ERET
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values
- cp0_we_i  in  1  CP0 write commits at the next edge (MTC0 in WB)
- cp0_waddr_i  in  5  CP0 write address (12 status, 13 cause, 14 epc)
- cp0_wdata_i  in  32  CP0 write data
- excepttype_o  out  32  to CP0: 1/4/5/8/9/a/c/d/e, or 0
- exc_pc_o  out  32  to CP0: faulting instruction address
- exc_delayslot_o  out  1  to CP0: delay-slot flag
- bad_addr_o  out  32  to CP0: faulting address
- flush_o  out  1  flush IF..MEM
- new_pc_o  out  32  redirect PC, valid while flush_o=1

## Operation
- Forwarding: when cp0_we_i=1 and cp0_waddr_i matches status, cause or epc, use cp0_wdata_i in place of that input. A cause write forwards only bits 9:8; bits 15:10 always come from cp0_cause_i.
- Interrupt pending: (status[15:8] & cause[15:8]) != 0, status[0]=1 and status[1]=0, all on forwarded values. It is only taken on a valid instruction.
- Priority, highest first: interrupt(1) > fetch AdEL(4) > RI(a) > syscall(8) > break(9) > overflow(c) > trap(d) > data AdEL(4) > data AdES(5) > ERET(e).
- bad_addr = pc_i for fetch AdEL, mem_addr_i for data AdEL/AdES, 0 otherwise.
- Redirect: ERET goes to the forwarded epc; all other types go to EXC_VECTOR.
- States: IDLE and FLUSH.
  - IDLE: a detection with mem_valid_i=1 and stall_i=0 registers the report and moves to FLUSH.
  - FLUSH: the next-state logic ignores every detection. The state returns to IDLE unconditionally after one cycle.
- Detection while stall_i=1 is held off. The flags stay on the inputs and commit on the first unstalled cycle.

## Timing
- Reset values: all outputs 0; state IDLE.
- Cycle T: detection, with mem_valid_i=1, stall_i=0, state IDLE.
- Edge T+1: excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o=1 and new_pc_o are registered.
  - All of them hold for exactly one cycle and return to 0 at edge T+2.
  - CP0 latches the report at edge T+2.
- During cycle T+1 the state is FLUSH. The instruction in MEM is squashed and cannot raise anything.
- The earliest next commit is a detection in cycle T+2, giving a report at edge T+3.
- A CP0 write and a detection in the same cycle: the forwarded value decides interrupt enable and the ERET target.
- Reset during FLUSH: outputs go to 0 at the next edge and state returns to IDLE.
- Multiple flags in one cycle produce exactly one report, the highest priority one.

## Test plan
- Overflow at pc 0x80001000, not in delay slot, IDLE.
  - Edge T+1: excepttype 0xc, exc_pc 0x80001000, delayslot 0, flush 1, new_pc 0xBFC00380.
  - Edge T+2: all outputs 0.
- Data AdES at pc 0x80000020, in delay slot, mem_addr 0x00000003.
  - Report: type 0x5, bad_addr 0x3, delayslot 1, exc_pc 0x80000020.
- Status 0x00000401, cause[10]=1, syscall also flagged.
  - Type 0x1 is reported.
  - Repeat with status[1]=1: type 0x8 is reported.
- ERET with epc 0x80000100 and a simultaneous MTC0 writing epc 0x80000200.
  - Type 0xe, new_pc 0x80000200.
- RI raised with stall_i=1 for 3 cycles: no output during the stall; the report appears one edge after stall_i falls.
  - Exceptions in consecutive cycles T and T+1: only T is reported.
  - Reset asserted in FLUSH: all outputs 0 next edge.
